// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 capture path: FSM states, the RGB444 pixel
// layout written to the frame buffer, and frame-size arithmetic.
package ov7670_pkg;

  typedef enum logic [1:0] {
    WAIT_VS,
    SYNC,
    ACTIVE
  } cap_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel444_t;

  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Registers the camera pins once and pairs RGB444 bytes into pixels.
// Byte 0 carries R in its low nibble, byte 1 carries {G, B}. A lone byte at
// the end of an href window is discarded because the phase clears while href
// is low. With OV7670_CAPTURE_GEOM_CHECK_EN defined, a line_end pulse is also
// produced on each registered href fall.
import ov7670_pkg::*;

module ov7670_byte_pair (
  input  logic       pclk,
  input  logic       rst,
  input  logic       clear,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vsync_q,
`ifdef OV7670_CAPTURE_GEOM_CHECK_EN
  output logic       line_end,
`endif
  output logic       pixel_valid,
  output pixel444_t  pixel
);

  logic       href_q;
  logic [7:0] data_q;
  logic       phase;
  logic [3:0] r_hold;

  // Input register stage, byte phase and held red nibble.
  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      phase   <= 1'b0;
      r_hold  <= '0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      data_q  <= cam_data;
      if (!href_q || clear) phase <= 1'b0;
      else                  phase <= ~phase;
      if (href_q && !phase) r_hold <= data_q[3:0];
    end
  end

  // Second byte of a pair completes a pixel unless the line is being abandoned.
  assign pixel_valid = href_q & phase & ~clear;
  assign pixel       = '{r: r_hold, g: data_q[7:4], b: data_q[3:0]};

`ifdef OV7670_CAPTURE_GEOM_CHECK_EN
  logic href_prev;

  // Delayed href used to detect the end of each line.
  always_ff @(posedge pclk) begin
    if (rst) href_prev <= 1'b0;
    else     href_prev <= href_q;
  end

  assign line_end = href_prev & ~href_q;
`endif

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture into a linear frame buffer. Waits for a complete vsync
// pulse after reset, discards SKIP_FRAMES frames, then writes one 12-bit pixel
// per byte pair at consecutive addresses starting from 0 each frame.
// Optional geometry checking is enabled with OV7670_CAPTURE_GEOM_CHECK_EN;
// without it frame_err is constant 0.
import ov7670_pkg::*;

module ov7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overflow,
  output logic              frame_err
);

  localparam int                FRAME_PIXELS = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam logic [ADDR_W-1:0] FRAME_END    = ADDR_W'(FRAME_PIXELS);
  localparam logic [7:0]        SKIP_INIT    = 8'(SKIP_FRAMES);

  cap_state_t        state, state_next;
  logic              vsync_q, vsync_prev, vs_rise;
  logic              pixel_valid, accept;
  pixel444_t         pixel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        skip_cnt;
`ifdef OV7670_CAPTURE_GEOM_CHECK_EN
  logic              line_end;
`endif

  ov7670_byte_pair u_byte_pair (
    .pclk        (pclk),
    .rst         (rst),
    .clear       (vs_rise),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .vsync_q     (vsync_q),
`ifdef OV7670_CAPTURE_GEOM_CHECK_EN
    .line_end    (line_end),
`endif
    .pixel_valid (pixel_valid),
    .pixel       (pixel)
  );

  assign vs_rise = vsync_q & ~vsync_prev;
  assign accept  = pixel_valid && (state == ACTIVE) && (skip_cnt == '0);

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (rst) state <= WAIT_VS;
    else     state <= state_next;
  end

  // Next-state logic: full vsync pulse, then active frame until the next rise.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      WAIT_VS: if (vsync_q)  state_next = SYNC;
      SYNC:    if (!vsync_q) state_next = ACTIVE;
      ACTIVE:  if (vs_rise)  state_next = SYNC;
      default:               state_next = WAIT_VS;
    endcase
  end

  // Write strobe, addressing, overflow, skip counter and frame accounting.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_prev  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      addr        <= '0;
      skip_cnt    <= SKIP_INIT;
    end else begin
      vsync_prev <= vsync_q;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (vs_rise) begin
        addr     <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        if (addr == FRAME_END) begin
          overflow <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= pixel;
          addr    <= addr + ADDR_W'(1);
        end
      end
      if (state == ACTIVE && vs_rise) begin
        if (skip_cnt == '0) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end else begin
          skip_cnt <= skip_cnt - 8'd1;
        end
      end
    end
  end

`ifdef OV7670_CAPTURE_GEOM_CHECK_EN
  logic [15:0] px_cnt, line_cnt, lines_now;
  logic        geom_bad, line_bad;

  assign line_bad  = line_end && (px_cnt != 16'(H_ACTIVE));
  assign lines_now = line_cnt + {15'd0, line_end};

  // Per-line pixel and per-frame line counting; verdict latched with frame_done.
  always_ff @(posedge pclk) begin
    if (rst) begin
      px_cnt    <= '0;
      line_cnt  <= '0;
      geom_bad  <= 1'b0;
      frame_err <= 1'b0;
    end else if (state != ACTIVE) begin
      px_cnt   <= '0;
      line_cnt <= '0;
      geom_bad <= 1'b0;
    end else if (vs_rise) begin
      if (skip_cnt == '0)
        frame_err <= geom_bad | line_bad | (lines_now != 16'(V_ACTIVE));
      px_cnt   <= '0;
      line_cnt <= '0;
      geom_bad <= 1'b0;
    end else if (line_end) begin
      px_cnt   <= '0;
      line_cnt <= line_cnt + 16'd1;
      if (line_bad) geom_bad <= 1'b1;
    end else if (pixel_valid) begin
      px_cnt <= px_cnt + 16'd1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture in a 4x2 configuration with two
// skipped frames. Expected writes go into a scoreboard queue as bytes are
// driven; a monitor pops and compares them whenever wr_en is seen.
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 19;
  localparam int FRAME = H * V;

  logic          pclk = 1'b0;
  logic          rst;
  logic          cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          wr_en, frame_done, overflow, frame_err;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [7:0]    frame_count;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(2)) dut (
    .pclk        (pclk),
    .rst         (rst),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp_data;
  } vec_t;

  typedef struct {
    int          addr;
    logic [11:0] data;
  } wr_t;

  vec_t vecs[FRAME];
  wr_t  exp_q[$];
  wr_t  e;
  int   total = 0;
  int   bad = 0;
  int   wr_seen = 0;
  int   fd_seen = 0;
  int   model_addr = 0;
  bit   model_on = 1'b0;
  int   w0, f0, exp_geom;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic send(input bit h, input logic [7:0] d);
    cam_href = h;
    cam_data = d;
    cyc();
  endtask

  task automatic gap(input int n);
    repeat (n) send(1'b0, 8'h00);
  endtask

  task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [11:0] exp_data);
    if (model_on && model_addr < FRAME) begin
      exp_q.push_back('{addr: model_addr, data: exp_data});
      model_addr++;
    end
    send(1'b1, b0);
    send(1'b1, b1);
  endtask

  task automatic vsync_pulse();
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) cyc();
    cam_vsync = 1'b0;
    repeat (3) cyc();
    model_addr = 0;
  endtask

  task automatic full_frame();
    for (int l = 0; l < V; l++) begin
      for (int p = 0; p < H; p++)
        send_pixel(vecs[l*H+p].b0, vecs[l*H+p].b1, vecs[l*H+p].exp_data);
      gap(3);
    end
  endtask

  initial begin
    // Pixel table: upper nibble of byte 0 is junk and must be ignored.
    vecs[0] = '{8'hF1, 8'h23, 12'h123};
    vecs[1] = '{8'h04, 8'h56, 12'h456};
    vecs[2] = '{8'hA7, 8'h89, 12'h789};
    vecs[3] = '{8'h3A, 8'hBC, 12'hABC};
    vecs[4] = '{8'h0D, 8'hEF, 12'hDEF};
    vecs[5] = '{8'hC0, 8'h00, 12'h000};
    vecs[6] = '{8'h5F, 8'hFF, 12'hFFF};
    vecs[7] = '{8'h96, 8'h3C, 12'h63C};
`ifdef OV7670_CAPTURE_GEOM_CHECK_EN
    exp_geom = 1;
`else
    exp_geom = 0;
`endif

    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
      forever begin
        @(negedge pclk);
        if (wr_en === 1'b1) begin
          wr_seen++;
          check("write_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", int'(wr_addr), e.addr);
            check("wr_data", int'(wr_data), int'(e.data));
          end
        end
        if (frame_done === 1'b1) begin
          fd_seen++;
          check("done_write_exclusive", int'(wr_en), 0);
        end
      end
    join_none

    // Reset state.
    rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) cyc();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    cyc();

    // Two skipped frames, then one written frame.
    model_on = 1'b0;
    vsync_pulse(); full_frame();
    vsync_pulse(); full_frame();
    check("t1_skip_no_writes", wr_seen, 0);
    vsync_pulse();
    model_on = 1'b1;
    full_frame();
    vsync_pulse();
    check("t1_writes", wr_seen, FRAME);
    check("t1_frame_done", fd_seen, 1);
    check("t1_frame_count", int'(frame_count), 1);

    // Exact write latency for bytes 0x0A, 0x5C.
    exp_q.push_back('{addr: 0, data: 12'hA5C});
    model_addr = 1;
    send(1'b1, 8'h0A);
    send(1'b1, 8'h5C);
    check("t2_wr_en_early", int'(wr_en), 0);
    send(1'b0, 8'h00);
    check("t2_wr_en", int'(wr_en), 1);
    check("t2_wr_data", int'(wr_data), 12'hA5C);
    check("t2_wr_addr", int'(wr_addr), 0);
    cyc();
    check("t2_wr_en_single", int'(wr_en), 0);

    // Odd-length line: lone byte dropped, next line pairs from phase 0.
    vsync_pulse();
    w0 = wr_seen;
    for (int p = 0; p < H; p++) send_pixel(vecs[p].b0, vecs[p].b1, vecs[p].exp_data);
    send(1'b1, 8'h03);
    gap(3);
    send_pixel(8'h01, 8'h23, 12'h123);
    gap(3);
    check("t3_writes", wr_seen - w0, H + 1);
    check("t3_next_line_addr", int'(wr_addr), H);
    check("t3_next_line_data", int'(wr_data), 12'h123);
    check("t3_frame_count", int'(frame_count), 2);

    // Three lines into a two-line frame: overflow, then cleared by vsync.
    vsync_pulse();
    w0 = wr_seen;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < H; p++)
        send_pixel(vecs[(l*H+p)%FRAME].b0, vecs[(l*H+p)%FRAME].b1,
                   vecs[(l*H+p)%FRAME].exp_data);
      gap(3);
    end
    check("t4_writes", wr_seen - w0, FRAME);
    check("t4_last_addr", int'(wr_addr), FRAME - 1);
    check("t4_overflow_set", int'(overflow), 1);
    vsync_pulse();
    check("t4_overflow_clear", int'(overflow), 0);
    check("t4_frame_count", int'(frame_count), 4);
    send_pixel(8'hF1, 8'h11, 12'h111);
    gap(3);
    check("t4_restart_addr", int'(wr_addr), 0);

    // Geometry: one short line, then a correct frame.
    vsync_pulse();
    for (int p = 0; p < 3; p++) send_pixel(vecs[p].b0, vecs[p].b1, vecs[p].exp_data);
    gap(3);
    f0 = fd_seen;
    vsync_pulse();
    check("t6_done_short", fd_seen - f0, 1);
    check("t6_frame_err_short", int'(frame_err), exp_geom);
    full_frame();
    vsync_pulse();
    check("t6_frame_err_good", int'(frame_err), 0);
    check("t6_frame_count", int'(frame_count), 7);

    // Reset mid-line, href activity before vsync, then skip and restart.
    send_pixel(vecs[0].b0, vecs[0].b1, vecs[0].exp_data);
    send_pixel(vecs[1].b0, vecs[1].b1, vecs[1].exp_data);
    send(1'b1, 8'hAB);
    rst = 1'b1;
    cyc();
    check("t5_rst_wr_en", int'(wr_en), 0);
    check("t5_rst_wr_addr", int'(wr_addr), 0);
    check("t5_rst_wr_data", int'(wr_data), 0);
    check("t5_rst_frame_count", int'(frame_count), 0);
    check("t5_rst_overflow", int'(overflow), 0);
    check("t5_rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    model_on = 1'b0;
    w0 = wr_seen;
    f0 = fd_seen;
    send(1'b1, 8'h12);
    for (int p = 0; p < H; p++) send_pixel(vecs[p].b0, vecs[p].b1, vecs[p].exp_data);
    gap(3);
    check("t5_no_write_before_vsync", wr_seen - w0, 0);
    vsync_pulse(); full_frame();
    vsync_pulse(); full_frame();
    vsync_pulse();
    model_on = 1'b1;
    full_frame();
    vsync_pulse();
    check("t5_writes_after_skip", wr_seen - w0, FRAME);
    check("t5_frame_done", fd_seen - f0, 1);
    check("t5_frame_count", int'(frame_count), 1);

    gap(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
Camera-side counterpart of the VGA scan-out path. Receives the OV7670 parallel pixel stream (vsync/href/8-bit data, RGB444 two-byte format) on the camera pixel clock. Assembles 12-bit pixels and issues linear frame-buffer write addresses, which the VGA controller later reads via d_r_addr. Sits between the camera pins and the frame-buffer BRAM write port.

Parameters:
H_ACTIVE, 640, pixels per line (2*H_ACTIVE bytes per href-high window)
V_ACTIVE, 480, lines per frame
ADDR_W, 19, frame-buffer address width; must hold H_ACTIVE*V_ACTIVE-1
SKIP_FRAMES, 2, whole frames discarded after reset while camera settles (0 = none)

Ports:
pclk  in  1  camera pixel clock; sole clock
rst  in  1  synchronous, active-high reset
cam_vsync  in  1  frame sync; high between frames
cam_href  in  1  line valid; high while bytes are valid
cam_data  in  8  pixel byte
wr_en  out  1  one-cycle frame-buffer write strobe
wr_addr  out  ADDR_W  write address, 0 at first pixel of frame
wr_data  out  12  {R[3:0],G[3:0],B[3:0]}
frame_done  out  1  one-cycle pulse at end of each written frame
frame_count  out  8  count of written frames; wraps 255->0
overflow  out  1  sticky per frame: pixels arrived beyond H_ACTIVE*V_ACTIVE
frame_err  out  1  geometry error flag (optional feature; else constant 0)

Behaviour:
- Clocking and reset: single clock pclk. Reset is synchronous and active-high. On rst, all outputs go to 0, FSM goes to WAIT_VS, byte phase = 0, address = 0, skip counter = SKIP_FRAMES.
- Input stage: cam_vsync, cam_href and cam_data are registered once before use.
- Byte pairing:
  - Byte 0 is {xxxx, R}; byte 1 is {G, B}.
  - The phase toggles on each registered href=1 cycle and clears whenever registered href=0.
  - A lone byte left at the href fall is discarded.
- Latency: bytes presented before edges k and k+1 produce wr_en=1 in the cycle after edge k+2 only. wr_data and wr_addr are valid in that same cycle.
- Address:
  - Increments by 1 after each write.
  - Cleared to 0 at every vsync rise.
  - Once it reaches H_ACTIVE*V_ACTIVE, further pixels are dropped (no wr_en) and overflow is set.
  - overflow clears at the next vsync rise.
- FSM:
  - WAIT_VS: wait for registered vsync = 1, then go to SYNC. Guarantees no partial frame after reset.
  - SYNC: on vsync fall, go to ACTIVE.
  - ACTIVE: pixels written if skip counter = 0. On vsync rise, go to SYNC, and:
    - If the frame was written: pulse frame_done for 1 cycle and increment frame_count.
    - Else: decrement the skip counter, with no frame_done.
- Edge cases:
  - vsync rise while href=1: the line is abandoned; any pending byte is discarded.
  - href high in WAIT_VS or SYNC: ignored.
  - Reset mid-frame: immediate return to WAIT_VS; no writes until a full vsync pulse has passed.
- frame_done and wr_en never assert in the same cycle. A final pixel completing at the vsync rise is written one cycle before frame_done.

Optional Feature:
Macro OV7670_CAPTURE_GEOM_CHECK_EN.
- Defined:
  - Counts pixels per line and lines per frame.
  - frame_err sets if any line has a pixel count ≠ H_ACTIVE, or the line count ≠ V_ACTIVE at the vsync rise.
  - frame_err is updated on the same cycle as frame_done and held until the next frame_done.
- Undefined: frame_err is tied to 0; the counters are not synthesized.

Decomposition:
- Package ov7670_pkg holds:
  - FSM state enum {WAIT_VS, SYNC, ACTIVE}.
  - Typedef pixel444_t (12-bit packed R,G,B).
  - Localparam function computing FRAME_PIXELS = H_ACTIVE*V_ACTIVE.
- One natural sub-module, ov7670_byte_pair: registered input stage plus phase toggle, emitting pixel_valid/pixel444_t.
- FSM, addressing and flags stay in the top module.

Test Plan:
- Reset, SKIP_FRAMES=2, 3 full 4x2 frames (H_ACTIVE=4, V_ACTIVE=2):
  - No wr_en in frames 1–2.
  - Frame 3 writes addr 0..7.
  - frame_done pulses once; frame_count = 1.
- Bytes 0x0A then 0x5C -> wr_data = 0xA5C, wr_en exactly 1 cycle, in the cycle after the third edge following byte 0.
- Line of 9 bytes (odd) -> 4 writes; the 9th byte is dropped; the next line starts at the correct address with phase 0.
- 3 lines in a 4x2 config -> 8 writes (addr 0..7), overflow = 1; the next vsync clears overflow and addr restarts at 0.
- rst asserted mid-line in frame 3 -> outputs 0; href activity before the next vsync pulse produces no wr_en; the following frame starts at addr 0.
- OV7670_CAPTURE_GEOM_CHECK_EN defined, one line of 3 pixels -> frame_err = 1 with frame_done; the next correct frame -> frame_err = 0.
